// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: converts an OV-style byte stream (vsync/href/data) into
// RGB444 frame-buffer writes with line-aligned addressing, plus per-frame
// line/pixel statistics and sticky error flags for debug.
module cam_pixel_capture #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int SYNC_FILT = 8
) (
  input  logic        cam_in_clk,
  input  logic        rstn,
  input  logic        cam_vsynk,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic        WriteEn,
  output logic [18:0] WriteAdd,
  output logic [11:0] WriteData,
  output logic        frame_start,
  output logic        frame_done,
  output logic [9:0]  line_count,
  output logic [10:0] last_line_len,
  output logic [3:0]  err_flags
);

  localparam logic [18:0] PIX_LIMIT = 19'(H_ACTIVE * V_ACTIVE);
  localparam logic [18:0] PIX_LAST  = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [18:0] H_STEP    = 19'(H_ACTIVE);
  localparam logic [10:0] H_LEN     = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LEN     = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  // input stage (S1)
  logic                 vsync_s1_q, vsync_s1_d;
  logic                 href_s1_q, href_s1_d;
  logic [7:0]           data_s1_q, data_s1_d;
  logic                 href_prev_q, href_prev_d;

  // vsync filter
  logic [SYNC_FILT-1:0] filt_q, filt_d;
  logic                 filt_full_q, filt_full_d;
  logic                 vs_start;

  // capture state
  state_t               state_q, state_d;
  logic [18:0]          line_base_q, line_base_d;
  logic [10:0]          column_q, column_d;
  logic                 phase_q, phase_d;
  logic [3:0]           red_q, red_d;
  logic [18:0]          pix_addr;

  // registered outputs
  logic                 write_en_q, write_en_d;
  logic [18:0]          write_add_q, write_add_d;
  logic [11:0]          write_data_q, write_data_d;
  logic                 frame_start_q, frame_start_d;
  logic                 frame_done_q, frame_done_d;
  logic [9:0]           line_count_q, line_count_d;
  logic [10:0]          last_line_len_q, last_line_len_d;
  logic [3:0]           err_flags_q, err_flags_d;

  // input register and vsync filter next-state
  always_comb begin
    vsync_s1_d  = cam_vsynk;
    href_s1_d   = cam_href;
    data_s1_d   = cam_data;
    href_prev_d = href_s1_q;
    filt_d      = {filt_q[SYNC_FILT-2:0], vsync_s1_q & ~href_s1_q};
    filt_full_d = (filt_q == '1);
    vs_start    = (filt_q == '1) && !filt_full_q;
  end

  // capture FSM, byte pairing, line close and statistics
  always_comb begin
    state_d         = state_q;
    line_base_d     = line_base_q;
    column_d        = column_q;
    phase_d         = phase_q;
    red_d           = red_q;
    write_en_d      = 1'b0;
    write_add_d     = write_add_q;
    write_data_d    = write_data_q;
    frame_start_d   = vs_start;
    frame_done_d    = 1'b0;
    line_count_d    = line_count_q;
    last_line_len_d = last_line_len_q;
    err_flags_d     = err_flags_q;
    pix_addr        = line_base_q + {8'd0, column_q};

    // Flags are cleared one cycle after the frame_start pulse so the
    // closing frame's status is still visible alongside frame_done.
    if (frame_start_q) begin
      err_flags_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (capture_en) begin
          state_d = WAIT_VS;
        end
      end

      WAIT_VS: begin
        if (vs_start) begin
          state_d      = ACTIVE;
          line_base_d  = '0;
          column_d     = '0;
          phase_d      = 1'b0;
          line_count_d = '0;
        end
      end

      ACTIVE: begin
        if (vs_start) begin
          frame_done_d = 1'b1;
          if (line_count_q != V_LEN) begin
            err_flags_d[3] = 1'b1;
          end
          if (capture_en) begin
            line_base_d  = '0;
            column_d     = '0;
            phase_d      = 1'b0;
            line_count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (href_s1_q) begin
          if (!phase_q) begin
            red_d   = data_s1_q[3:0];
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (column_q != 11'h7FF) begin
              column_d = column_q + 11'd1;
            end
            if (column_q < H_LEN) begin
              if (pix_addr <= PIX_LAST) begin
                write_en_d   = 1'b1;
                write_add_d  = pix_addr;
                write_data_d = {red_q, data_s1_q};
              end else begin
                err_flags_d[2] = 1'b1;
              end
            end
          end
        end else begin
          phase_d = 1'b0;
          if (href_prev_q) begin
            last_line_len_d = column_q;
            if (column_q != H_LEN) begin
              err_flags_d[0] = 1'b1;
            end
            if (phase_q) begin
              err_flags_d[1] = 1'b1;
            end
            if (line_base_q < PIX_LIMIT) begin
              line_base_d = line_base_q + H_STEP;
            end
            if (line_count_q != 10'h3FF) begin
              line_count_d = line_count_q + 10'd1;
            end
            column_d = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // all state registers, asynchronous active-low reset
  always_ff @(posedge cam_in_clk or negedge rstn) begin
    if (!rstn) begin
      vsync_s1_q      <= 1'b0;
      href_s1_q       <= 1'b0;
      data_s1_q       <= '0;
      href_prev_q     <= 1'b0;
      filt_q          <= '0;
      filt_full_q     <= 1'b0;
      state_q         <= IDLE;
      line_base_q     <= '0;
      column_q        <= '0;
      phase_q         <= 1'b0;
      red_q           <= '0;
      write_en_q      <= 1'b0;
      write_add_q     <= '0;
      write_data_q    <= '0;
      frame_start_q   <= 1'b0;
      frame_done_q    <= 1'b0;
      line_count_q    <= '0;
      last_line_len_q <= '0;
      err_flags_q     <= '0;
    end else begin
      vsync_s1_q      <= vsync_s1_d;
      href_s1_q       <= href_s1_d;
      data_s1_q       <= data_s1_d;
      href_prev_q     <= href_prev_d;
      filt_q          <= filt_d;
      filt_full_q     <= filt_full_d;
      state_q         <= state_d;
      line_base_q     <= line_base_d;
      column_q        <= column_d;
      phase_q         <= phase_d;
      red_q           <= red_d;
      write_en_q      <= write_en_d;
      write_add_q     <= write_add_d;
      write_data_q    <= write_data_d;
      frame_start_q   <= frame_start_d;
      frame_done_q    <= frame_done_d;
      line_count_q    <= line_count_d;
      last_line_len_q <= last_line_len_d;
      err_flags_q     <= err_flags_d;
    end
  end

  assign WriteEn       = write_en_q;
  assign WriteAdd      = write_add_q;
  assign WriteData     = write_data_q;
  assign frame_start   = frame_start_q;
  assign frame_done    = frame_done_q;
  assign line_count    = line_count_q;
  assign last_line_len = last_line_len_q;
  assign err_flags     = err_flags_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Testbench for cam_pixel_capture, using a reduced 8x4 frame geometry.
module tb_cam_pixel_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SF = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vs = 1'b0;
  logic        hr = 1'b0;
  logic        cen = 1'b0;
  logic [7:0]  dat = 8'd0;

  logic        WriteEn;
  logic [18:0] WriteAdd;
  logic [11:0] WriteData;
  logic        frame_start;
  logic        frame_done;
  logic [9:0]  line_count;
  logic [10:0] last_line_len;
  logic [3:0]  err_flags;

  cam_pixel_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .SYNC_FILT(SF)
  ) dut (
    .cam_in_clk   (clk),
    .rstn         (rstn),
    .cam_vsynk    (vs),
    .cam_href     (hr),
    .cam_data     (dat),
    .capture_en   (cen),
    .WriteEn      (WriteEn),
    .WriteAdd     (WriteAdd),
    .WriteData    (WriteData),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .line_count   (line_count),
    .last_line_len(last_line_len),
    .err_flags    (err_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard of expected {address, data}
  logic [30:0] sb[$];
  int          fs_cnt = 0;
  int          fd_cnt = 0;
  int          wr_cnt = 0;
  logic [3:0]  fd_err = 4'd0;
  logic        fd_fs  = 1'b0;
  logic        prev_we = 1'b0;

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [30:0] e;
    if (frame_start) fs_cnt++;
    if (frame_done) begin
      fd_cnt++;
      fd_err = err_flags;
      fd_fs  = frame_start;
    end
    if (WriteEn) begin
      wr_cnt++;
      check("write_spacing", 32'(prev_we), 32'd0);
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("write_addr", 32'(WriteAdd), 32'(e[30:12]));
        check("write_data", 32'(WriteData), 32'(e[11:0]));
      end
    end
    prev_we = WriteEn;
  end

  // bench model state
  logic m_active = 1'b0;
  int   m_line   = 0;

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    vs  = v;
    hr  = h;
    dat = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_line(input int nbytes, input bit fixed, input bit close);
    logic [7:0] b0;
    logic [7:0] b1;
    int col;
    col = 0;
    b0 = 8'd0;
    for (int b = 0; b < nbytes; b++) begin
      if (b % 2 == 0) begin
        b0 = fixed ? 8'h0A : 8'($urandom_range(0, 255));
        cyc(1'b0, 1'b1, b0);
      end else begin
        b1 = fixed ? 8'hBC : 8'($urandom_range(0, 255));
        if (m_active && col < H && (m_line * H + col) < H * V)
          sb.push_back({19'(m_line * H + col), b0[3:0], b1});
        col++;
        cyc(1'b0, 1'b1, b1);
      end
    end
    if (close) begin
      idle(4);
      m_line++;
    end
  endtask

  task automatic vsync_pulse(input int len, output int lat);
    lat = 0;
    for (int i = 1; i <= len + 4; i++) begin
      cyc(i <= len, 1'b0, 8'd0);
      if (frame_start && lat == 0) lat = i;
    end
  endtask

  initial begin
    int lat;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(WriteEn), 32'd0);
    check("rst_addr", 32'(WriteAdd), 32'd0);
    check("rst_data", 32'(WriteData), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    check("rst_lc", 32'(line_count), 32'd0);
    check("rst_len", 32'(last_line_len), 32'd0);
    check("rst_err", 32'(err_flags), 32'd0);
    rstn = 1'b1;
    idle(2);
    cen = 1'b1;
    idle(2);

    // short vsync glitch: no frame, later line ignored
    vsync_pulse(5, lat);
    check("glitch_fs_cnt", 32'(fs_cnt), 32'd0);
    send_line(2 * H, 1'b0, 1'b1);

    // real vsync: WAIT_VS -> ACTIVE, no frame_done
    vsync_pulse(10, lat);
    check("fs_latency", 32'(lat), 32'(SF + 2));
    check("fs_cnt_1", 32'(fs_cnt), 32'd1);
    check("fd_cnt_0", 32'(fd_cnt), 32'd0);
    m_active = 1'b1;
    m_line   = 0;

    // frame 1: clean frame with fixed pixel 0xABC
    for (int l = 0; l < V; l++) send_line(2 * H, 1'b1, 1'b1);
    check("f1_lc", 32'(line_count), 32'(V));
    check("f1_len", 32'(last_line_len), 32'(H));
    check("f1_err", 32'(err_flags), 32'd0);
    vsync_pulse(10, lat);
    m_line = 0;
    check("f1_fd_cnt", 32'(fd_cnt), 32'd1);
    check("f1_fd_err", 32'(fd_err), 32'd0);
    check("f1_fd_with_fs", 32'(fd_fs), 32'd1);
    check("f1_fs_cnt", 32'(fs_cnt), 32'd2);
    check("f2_lc_cleared", 32'(line_count), 32'd0);

    // frame 2: long line, short odd line
    send_line(2 * H + 4, 1'b0, 1'b1);
    check("long_len", 32'(last_line_len), 32'(H + 2));
    check("long_err", 32'(err_flags), 32'b0001);
    send_line(2 * H, 1'b0, 1'b1);
    check("norm_len", 32'(last_line_len), 32'(H));
    send_line(2 * H - 5, 1'b0, 1'b1);
    check("odd_len", 32'(last_line_len), 32'((2 * H - 5) / 2));
    check("odd_err", 32'(err_flags), 32'b0011);
    check("odd_lc", 32'(line_count), 32'd3);
    send_line(2 * H, 1'b0, 1'b1);
    vsync_pulse(10, lat);
    m_line = 0;
    check("f2_fd_cnt", 32'(fd_cnt), 32'd2);
    check("f2_fd_err", 32'(fd_err), 32'b0011);
    check("f3_err_cleared", 32'(err_flags), 32'd0);

    // frame 3: overlong frame, capture_en dropped mid-frame
    send_line(2 * H, 1'b0, 1'b1);
    send_line(2 * H, 1'b0, 1'b1);
    cen = 1'b0;
    for (int l = 2; l < V + 2; l++) send_line(2 * H, 1'b0, 1'b1);
    check("f3_err_ovf", 32'(err_flags), 32'b0100);
    check("f3_lc", 32'(line_count), 32'(V + 2));
    vsync_pulse(10, lat);
    m_active = 1'b0;
    m_line   = 0;
    check("f3_fd_cnt", 32'(fd_cnt), 32'd3);
    check("f3_fd_err", 32'(fd_err), 32'b1100);
    send_line(2 * H, 1'b0, 1'b1);
    vsync_pulse(10, lat);
    check("idle_no_fd", 32'(fd_cnt), 32'd3);
    send_line(2 * H, 1'b0, 1'b1);

    // reset in the middle of a line
    cen = 1'b1;
    idle(2);
    vsync_pulse(10, lat);
    m_active = 1'b1;
    m_line   = 0;
    send_line(2 * H, 1'b0, 1'b1);
    send_line(2 * H, 1'b0, 1'b1);
    send_line(7, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_we", 32'(WriteEn), 32'd0);
    check("mid_rst_addr", 32'(WriteAdd), 32'd0);
    check("mid_rst_data", 32'(WriteData), 32'd0);
    check("mid_rst_lc", 32'(line_count), 32'd0);
    check("mid_rst_len", 32'(last_line_len), 32'd0);
    check("mid_rst_err", 32'(err_flags), 32'd0);
    hr = 1'b0;
    @(posedge clk);
    #1;
    idle(3);
    rstn = 1'b1;
    m_active = 1'b0;
    m_line   = 0;
    idle(2);
    send_line(2 * H, 1'b0, 1'b1);
    vsync_pulse(10, lat);
    check("post_rst_fs_latency", 32'(lat), 32'(SF + 2));
    m_active = 1'b1;
    m_line   = 0;
    send_line(2 * H, 1'b0, 1'b1);
    check("post_rst_lc", 32'(line_count), 32'd1);

    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("total_writes", 32'(wr_cnt), 32'd120);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
# cam_pixel_capture

Camera-side capture stage that turns the OV-style byte stream (cam_vsynk, cam_href, cam_data) into 12-bit RGB444 pixel writes for the frame-buffer MemoryBlock write port. It runs entirely in the cam_in_clk domain, filters vsync, pairs bytes into pixels, generates line-aligned frame-buffer addresses and reports per-frame line/pixel statistics and error flags for debug and ILA probing.

## Interface
- H_ACTIVE, 640, pixels per line written to memory
- V_ACTIVE, 480, lines per frame written to memory
- SYNC_FILT, 8, vsync filter depth in cycles (2..16)

- cam_in_clk  in  1  camera pixel clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- cam_vsynk  in  1  raw camera vsync, active-high
- cam_href  in  1  raw camera line valid
- cam_data  in  8  raw camera byte
- capture_en  in  1  level; enables frame capture (quasi-static)
- WriteEn  out  1  one-cycle pixel write strobe
- WriteAdd  out  19  pixel address, line*H_ACTIVE + column
- WriteData  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- frame_start  out  1  one-cycle pulse at filtered vsync rise
- frame_done  out  1  one-cycle pulse when a captured frame closes
- line_count  out  10  lines completed in current frame
- last_line_len  out  11  pixels seen in most recently closed line
- err_flags  out  4  sticky: [0] line length != H_ACTIVE, [1] odd byte count in line, [2] address overflow, [3] frame line count != V_ACTIVE; cleared on frame_start

## Operation
- Input stage: cam_vsynk, cam_href, cam_data registered once (stage S1); all further logic uses S1 values.
- Vsync filter: SYNC_FILT-bit shift register of (vsync_s1 & ~href_s1); vs_start = register becomes all-ones from not all-ones; frame_start = vs_start.
- FSM states: IDLE, WAIT_VS, ACTIVE.
  - IDLE: no writes; capture_en=1 -> WAIT_VS.
  - WAIT_VS: on vs_start -> ACTIVE; clear line_base, column, phase, line_count.
  - ACTIVE: on vs_start -> pulse frame_done, set err_flags[3] if line_count != V_ACTIVE; then if capture_en=1 restart frame (stay ACTIVE, counters cleared), else -> IDLE. capture_en falling mid-frame never truncates a frame.
- Byte pairing (ACTIVE, href_s1=1): phase 0 latches byte0[3:0] as R; phase 1 forms pixel {R, byte1[7:0]} and issues a write if column < H_ACTIVE and line_base+column <= H_ACTIVE*V_ACTIVE-1; column increments on every phase-1 byte (also beyond H_ACTIVE, saturating at 2047). Suppressed write with column < H_ACTIVE but address over limit sets err_flags[2].
- Line close (href_s1 falling in ACTIVE): last_line_len <= column; err_flags[0] if column != H_ACTIVE; err_flags[1] if phase=1 (dangling byte dropped); line_base += H_ACTIVE; line_count += 1 (saturate 1023); column, phase cleared.
- href_s1 low clears phase; href pulses in WAIT_VS/IDLE ignored.
- Address arithmetic 19 bits, no multiplier; line_base never exceeds H_ACTIVE*V_ACTIVE (stops incrementing there).

## Timing
- Reset: FSM IDLE; WriteEn 0, WriteAdd 0, WriteData 0, frame_start 0, frame_done 0, line_count 0, last_line_len 0, err_flags 0, filter register 0. Reset mid-frame aborts immediately; next capture waits for a fresh vs_start.
- Write latency: byte1 on cam_data at edge k -> S1 at k -> WriteEn/WriteAdd/WriteData registered, valid for exactly the cycle after edge k+1. Max one write per two cycles.
- frame_start asserts SYNC_FILT+1 cycles after vsync high with href low; glitches shorter than SYNC_FILT cycles produce nothing.
- line_count/last_line_len/err_flags update the cycle after href_s1 falls; frame_done and frame_start coincide on the same cycle when in ACTIVE.

## Test plan
- Full frame: capture_en=1, vsync 10 cycles, 480 lines of 1280 bytes (byte0=0x0A, byte1=0xBC) -> 307200 writes, data 0xABC, addresses 0..307199 contiguous, frame_done at next vsync, err_flags=0, line_count=480.
- Vsync glitch: vsync high 5 cycles (SYNC_FILT=8) -> no frame_start, FSM stays WAIT_VS.
- Short/odd line: line 3 with 1001 bytes -> 500 writes at 1920..2419, last_line_len=500, err_flags[0]=1, err_flags[1]=1, line 4 starts at address 2560.
- Long frame: 482 lines of 1280 bytes -> writes stop after 307199, err_flags[2]=1 and err_flags[3]=1 at frame close.
- capture_en dropped mid-frame line 200 -> remaining lines still written, frame_done at next vsync, then IDLE, no further writes.
- rstn asserted at line 100 -> all outputs 0 same cycle; after release, no writes until a new filtered vsync.
